// File: rtl/mult_err_sweep_ctrl.sv
// Drives an exact and an approximate multiplier with identical operand pairs
// (exhaustive or LFSR sweep) and accumulates mismatch/error-distance statistics.
module mult_err_sweep_ctrl #(
    parameter int W     = 8,
    parameter int LAT   = 0,
    parameter int CNT_W = 32,
    parameter int SUM_W = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic [2*W-1:0]     seed,
    output logic [W-1:0]       op_a,
    output logic [W-1:0]       op_b,
    input  logic [2*W-1:0]     exact_prod,
    input  logic [2*W-1:0]     approx_prod,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [SUM_W-1:0]   sum_ed,
    output logic [2*W-1:0]     max_ed
);
    localparam int PW = 2 * W;
    localparam int AW = ((SUM_W > PW) ? SUM_W : PW) + 1;
    localparam logic [AW-1:0] SUM_MAX = AW'({SUM_W{1'b1}});

    // Right-shift Galois toggle masks for maximal-length sequences.
    function automatic logic [PW-1:0] lfsr_taps();
        logic [63:0] m;
        case (PW)
            4:       m = 64'hC;
            6:       m = 64'h30;
            8:       m = 64'hB8;
            10:      m = 64'h240;
            12:      m = 64'hE08;
            14:      m = 64'h3802;
            16:      m = 64'hB400;
            20:      m = 64'h90000;
            24:      m = 64'hE10000;
            32:      m = 64'h80200003;
            default: m = (64'h1 << (PW - 1)) | 64'h1;
        endcase
        return m[PW-1:0];
    endfunction

    localparam logic [PW-1:0] TAPS = lfsr_taps();

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic             mode_q;
    logic [CNT_W-1:0] rem;
    logic [PW-1:0]    lfsr;
    logic [LAT:0]     vld_pipe;

    logic [PW-1:0] seed_eff, lfsr_step, ed;
    logic [AW-1:0] sum_wide;
    logic          accept, zero_run, last_pair, issue_more, issue, acc;

    assign seed_eff   = (seed == '0) ? PW'(1) : seed;
    assign lfsr_step  = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign accept     = (state == IDLE) && start;
    assign zero_run   = mode && (num_samples == '0);
    // Exhaustive sweep ends on (max,max); random ends when the countdown hits 0.
    assign last_pair  = mode_q ? (rem == '0) : (&{op_a, op_b});
    assign issue_more = (state == ISSUE) && !last_pair;
    assign issue      = (accept && !zero_run) || issue_more;
    assign acc        = vld_pipe[LAT];

    assign ed       = (exact_prod >= approx_prod) ? (exact_prod - approx_prod)
                                                  : (approx_prod - exact_prod);
    assign sum_wide = AW'(sum_ed) + AW'(ed);

    assign busy = (state == ISSUE) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_run ? DONE : ISSUE;
            ISSUE:   if (last_pair) state_nxt = DRAIN;
            DRAIN:   if (vld_pipe == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            lfsr     <= PW'(1);
            mode_q   <= 1'b0;
            rem      <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | (LAT+1)'(issue);
            if (accept) begin
                mode_q <= mode;
                rem    <= num_samples - CNT_W'(1);
                if (mode) begin
                    lfsr         <= seed_eff;
                    {op_a, op_b} <= seed_eff;
                end else begin
                    {op_a, op_b} <= '0;
                end
            end else if (issue_more) begin
                rem <= rem - CNT_W'(1);
                if (mode_q) begin
                    lfsr         <= lfsr_step;
                    {op_a, op_b} <= lfsr_step;
                end else begin
                    {op_a, op_b} <= {op_a, op_b} + PW'(1);
                end
            end
        end
    end

    // The valid pipe is always empty in IDLE, so clear and accumulate never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (accept) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (acc) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            err_cnt    <= err_cnt + CNT_W'(ed != '0);
            sum_ed     <= (sum_wide > SUM_MAX) ? '1 : sum_wide[SUM_W-1:0];
            if (ed > max_ed) max_ed <= ed;
        end
    end
endmodule

// File: tb/tb_mult_err_sweep_ctrl.sv
// Directed bench: W=4/LAT=0 exhaustive sweeps and W=8/LAT=2 random sweeps
// against behavioural multipliers and an independent statistics model.
module tb_mult_err_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // W=4, LAT=0 instance
    logic        s4_start, s4_mode;
    logic [31:0] s4_num;
    logic [7:0]  s4_seed;
    logic [3:0]  a4, b4;
    logic [7:0]  ex4, ap4;
    logic        busy4, done4;
    logic [31:0] sc4, ec4;
    logic [47:0] se4;
    logic [7:0]  me4;
    int          amode4;

    assign ex4 = {4'b0, a4} * {4'b0, b4};
    always_comb begin
        ap4 = ex4;
        if (amode4 == 1)      ap4 = ex4 ^ 8'h01;
        else if (amode4 == 2) ap4 = 8'h00;
    end

    mult_err_sweep_ctrl #(.W(4), .LAT(0), .CNT_W(32), .SUM_W(48)) u4 (
        .clk(clk), .rst(rst), .start(s4_start), .mode(s4_mode),
        .num_samples(s4_num), .seed(s4_seed), .op_a(a4), .op_b(b4),
        .exact_prod(ex4), .approx_prod(ap4), .busy(busy4), .done(done4),
        .sample_cnt(sc4), .err_cnt(ec4), .sum_ed(se4), .max_ed(me4)
    );

    // W=8, LAT=2 instance with a small accumulator so saturation is reached
    logic        s8_start, s8_mode;
    logic [31:0] s8_num;
    logic [15:0] s8_seed;
    logic [7:0]  a8, b8;
    logic [15:0] ex8, ap8, ex_d1, ex_d2, ap_d1, ap_d2;
    logic        busy8, done8;
    logic [31:0] sc8, ec8;
    logic [11:0] se8;
    logic [15:0] me8;

    always @(posedge clk) begin
        ex_d1 <= {8'b0, a8} * {8'b0, b8};
        ap_d1 <= {8'b0, a8 & 8'hFE} * {8'b0, b8 & 8'hFE};
        ex_d2 <= ex_d1;
        ap_d2 <= ap_d1;
    end
    assign ex8 = ex_d2;
    assign ap8 = ap_d2;

    mult_err_sweep_ctrl #(.W(8), .LAT(2), .CNT_W(32), .SUM_W(12)) u8 (
        .clk(clk), .rst(rst), .start(s8_start), .mode(s8_mode),
        .num_samples(s8_num), .seed(s8_seed), .op_a(a8), .op_b(b8),
        .exact_prod(ex8), .approx_prod(ap8), .busy(busy8), .done(done8),
        .sample_cnt(sc8), .err_cnt(ec8), .sum_ed(se8), .max_ed(me8)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Exhaustive sweep on u4; cyc = clock edges from the start edge until done is seen.
    task automatic run4(input bit seq_chk, input int pulse_at, output int cyc);
        @(negedge clk);
        s4_mode  = 1'b0;
        s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        cyc = 0;
        chk("busy4_after_start", longint'(busy4), 1);
        while (!done4 && cyc < 2000) begin
            if (seq_chk && cyc < 256) begin
                chk("op_a_seq", longint'(a4), longint'(cyc >> 4));
                chk("op_b_seq", longint'(b4), longint'(cyc & 15));
            end
            s4_start = (cyc == pulse_at);
            @(negedge clk);
            cyc++;
        end
        s4_start = 1'b0;
    endtask

    task automatic run8(input logic [31:0] num, input logic [15:0] seed,
                        output int cyc, output logic [7:0] fa, output logic [7:0] fb);
        @(negedge clk);
        s8_mode  = 1'b1;
        s8_num   = num;
        s8_seed  = seed;
        s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        fa  = a8;
        fb  = b8;
        cyc = 0;
        while (!done8 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic model8(input logic [15:0] seed, input int num,
                          output int cnt, output int err, output longint sum, output int mx);
        logic [15:0] l;
        int a, b, ex, ap, ed;
        bit lsb;
        l = (seed == 16'h0) ? 16'h1 : seed;
        cnt = 0; err = 0; sum = 0; mx = 0;
        for (int i = 0; i < num; i++) begin
            a  = int'(l[15:8]);
            b  = int'(l[7:0]);
            ex = a * b;
            ap = (a & 254) * (b & 254);
            ed = (ex > ap) ? ex - ap : ap - ex;
            cnt++;
            if (ed != 0) err++;
            sum = sum + ed;
            if (sum > 4095) sum = 4095;
            if (ed > mx) mx = ed;
            lsb = l[0];
            l = l >> 1;
            if (lsb) l = l ^ 16'hB400;
        end
    endtask

    typedef struct {
        int     amode;
        int     exp_cyc;
        int     exp_cnt;
        int     exp_err;
        longint exp_sum;
        int     exp_max;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int cyc, m_cnt, m_err, m_max;
        longint m_sum;
        logic [7:0] fa, fb;

        vecs[0] = '{amode: 0, exp_cyc: 257, exp_cnt: 256, exp_err: 0,   exp_sum: 0,     exp_max: 0};
        vecs[1] = '{amode: 1, exp_cyc: 257, exp_cnt: 256, exp_err: 256, exp_sum: 256,   exp_max: 1};
        vecs[2] = '{amode: 2, exp_cyc: 257, exp_cnt: 256, exp_err: 225, exp_sum: 14400, exp_max: 225};

        s4_start = 0; s4_mode = 0; s4_num = 0; s4_seed = 0; amode4 = 0;
        s8_start = 0; s8_mode = 0; s8_num = 0; s8_seed = 0;
        repeat (3) @(negedge clk);
        chk("rst_op_a4", longint'(a4), 0);
        chk("rst_op_b4", longint'(b4), 0);
        chk("rst_busy4", longint'(busy4), 0);
        chk("rst_done4", longint'(done4), 0);
        chk("rst_sc4", longint'(sc4), 0);
        chk("rst_op_a8", longint'(a8), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            amode4 = vecs[i].amode;
            run4(i == 1, -1, cyc);
            chk("ex_done_cycles", longint'(cyc), longint'(vecs[i].exp_cyc));
            chk("ex_sample_cnt", longint'(sc4), longint'(vecs[i].exp_cnt));
            chk("ex_err_cnt", longint'(ec4), longint'(vecs[i].exp_err));
            chk("ex_sum_ed", longint'(se4), vecs[i].exp_sum);
            chk("ex_max_ed", longint'(me4), longint'(vecs[i].exp_max));
            @(negedge clk);
            chk("ex_done_pulse", longint'(done4), 0);
            chk("ex_busy_idle", longint'(busy4), 0);
        end

        // Repeat of vector 1 with a start pulse mid-sweep and another while in DONE.
        amode4 = 1;
        run4(1'b0, 100, cyc);
        chk("rep_cycles", longint'(cyc), 257);
        chk("rep_sample_cnt", longint'(sc4), 256);
        chk("rep_err_cnt", longint'(ec4), 256);
        chk("rep_sum_ed", longint'(se4), 256);
        s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        chk("start_in_done_busy", longint'(busy4), 0);
        @(negedge clk);
        chk("start_in_done_busy2", longint'(busy4), 0);
        chk("start_in_done_cnt", longint'(sc4), 256);
        chk("start_in_done_max", longint'(me4), 1);

        // Reset in the middle of ISSUE
        @(negedge clk);
        s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_busy", longint'(busy4), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_op_a", longint'(a4), 0);
        chk("mid_rst_op_b", longint'(b4), 0);
        chk("mid_rst_busy", longint'(busy4), 0);
        chk("mid_rst_sc", longint'(sc4), 0);
        chk("mid_rst_se", longint'(se4), 0);
        chk("mid_rst_me", longint'(me4), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", longint'(busy4), 0);
        chk("post_rst_done", longint'(done4), 0);
        chk("post_rst_sc", longint'(sc4), 0);

        // Random sweep, LAT=2
        run8(32'd1000, 16'hACE1, cyc, fa, fb);
        model8(16'hACE1, 1000, m_cnt, m_err, m_sum, m_max);
        chk("rnd_cycles", longint'(cyc), 1003);
        chk("rnd_first_a", longint'(fa), 'hAC);
        chk("rnd_first_b", longint'(fb), 'hE1);
        chk("rnd_sample_cnt", longint'(sc8), longint'(m_cnt));
        chk("rnd_err_cnt", longint'(ec8), longint'(m_err));
        chk("rnd_sum_ed", longint'(se8), m_sum);
        chk("rnd_max_ed", longint'(me8), longint'(m_max));

        // Zero-sample random run goes straight to DONE with cleared statistics
        run8(32'd0, 16'h1234, cyc, fa, fb);
        chk("zero_cycles", longint'(cyc), 0);
        chk("zero_busy", longint'(busy8), 0);
        chk("zero_sample_cnt", longint'(sc8), 0);
        chk("zero_err_cnt", longint'(ec8), 0);
        chk("zero_sum_ed", longint'(se8), 0);
        chk("zero_max_ed", longint'(me8), 0);

        // Seed 0 is replaced by 1
        run8(32'd3, 16'h0000, cyc, fa, fb);
        model8(16'h0000, 3, m_cnt, m_err, m_sum, m_max);
        chk("seed0_first_a", longint'(fa), 'h00);
        chk("seed0_first_b", longint'(fb), 'h01);
        chk("seed0_cycles", longint'(cyc), 6);
        chk("seed0_sample_cnt", longint'(sc8), longint'(m_cnt));
        chk("seed0_err_cnt", longint'(ec8), longint'(m_err));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
